// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid,
// bubble-masked control field, synchronous flush and saturating statistics.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 79,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_vld_q, main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              cnt_en_q, cnt_en_d;
    logic              push, pop;

    assign push = in_valid & in_ready;
    assign pop  = main_vld_q & out_ready;

    generate
        if (SKID != 0) begin : g_rdy_skid
            // Registered ready: only the skid occupancy and the flush kill matter.
            assign in_ready = ~skid_vld_q & ~flush;
        end else begin : g_rdy_comb
            assign in_ready = (~main_vld_q | out_ready) & ~flush;
        end
    endgenerate

    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
        end else if (!main_vld_q || pop) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = push;
                if (push) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end
            end else begin
                main_vld_d = push;
                if (push) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    skid_vld_q  <= 1'b0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    skid_vld_q  <= skid_vld_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    skid_data_q <= skid_data_d;
                end
            end
        end else begin : g_no_skid
            assign skid_vld_q  = 1'b0;
            assign skid_ctrl_q = '0;
            assign skid_data_q = '0;
        end
    endgenerate

    // Counters start one clock after reset release.
    always_comb begin
        cnt_en_d = 1'b1;
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (clr_stats) begin
            stall_d  = '0;
            bubble_d = '0;
        end else if (cnt_en_q) begin
            if (main_vld_q && !out_ready && stall_q != '1)
                stall_d = stall_q + CNT_W'(1);
            if (!main_vld_q && bubble_q != '1)
                bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_en_q <= 1'b0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            cnt_en_q <= cnt_en_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid  = main_vld_q;
    assign out_ctrl   = main_ctrl_q & {CTRL_W{main_vld_q}};
    assign out_data   = main_data_q;
    assign occupancy  = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1, SKID=0 and CNT_W=4 instances share stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, clr_stats, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [78:0] in_data;

    logic        s1_in_ready, s1_out_valid;
    logic [7:0]  s1_out_ctrl;
    logic [78:0] s1_out_data;
    logic [1:0]  s1_occ;
    logic [15:0] s1_stall, s1_bubble;

    logic        s0_in_ready, s0_out_valid;
    logic [7:0]  s0_out_ctrl;
    logic [78:0] s0_out_data;
    logic [1:0]  s0_occ;
    logic [15:0] s0_stall, s0_bubble;

    logic        c4_in_ready, c4_out_valid;
    logic [7:0]  c4_out_ctrl;
    logic [78:0] c4_out_data;
    logic [1:0]  c4_occ;
    logic [3:0]  c4_stall, c4_bubble;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(79), .SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(s1_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_ctrl(s1_out_ctrl),
        .out_data(s1_out_data), .occupancy(s1_occ), .stall_cnt(s1_stall), .bubble_cnt(s1_bubble));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(79), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(s0_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_ctrl(s0_out_ctrl),
        .out_data(s0_out_data), .occupancy(s0_occ), .stall_cnt(s0_stall), .bubble_cnt(s0_bubble));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(79), .SKID(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(c4_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out_ctrl(c4_out_ctrl),
        .out_data(c4_out_data), .occupancy(c4_occ), .stall_cnt(c4_stall), .bubble_cnt(c4_bubble));

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [78:0] d, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_valid", s1_out_valid, 0);
        chk("rst_ctrl", s1_out_ctrl, 0);
        chk("rst_data", s1_out_data, 0);
        chk("rst_occ", s1_occ, 0);
        chk("rst_stall", s1_stall, 0);
        chk("rst_bubble", s1_bubble, 0);
        chk("rst_in_ready", s1_in_ready, 1);
        chk("rst_in_ready_s0", s0_in_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick;

        // 1: stream of five beats, one-cycle latency, no gaps
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h11 + i), 79'(i + 1), 1'b1);
            tick;
            chk("strm_valid", s1_out_valid, 1);
            chk("strm_ctrl", s1_out_ctrl, 96'(8'h11 + i));
            chk("strm_data", s1_out_data, 96'(i + 1));
        end
        drive(1'b0, 8'h00, 79'h0, 1'b1);
        tick;
        chk("strm_end_valid", s1_out_valid, 0);
        chk("strm_bubble1", s1_bubble, 1);
        tick;
        chk("strm_bubble2", s1_bubble, 2);

        // 2: backpressure absorbs two beats, third held upstream
        drive(1'b1, 8'hA0, 79'hA, 1'b0);
        chk("bp_rdy_a", s1_in_ready, 1);
        tick;
        chk("bp_occ1", s1_occ, 1);
        chk("bp_ctrl_a", s1_out_ctrl, 8'hA0);
        drive(1'b1, 8'hB0, 79'hB, 1'b0);
        tick;
        chk("bp_occ2", s1_occ, 2);
        chk("bp_rdy_low", s1_in_ready, 0);
        drive(1'b1, 8'hC0, 79'hC, 1'b0);
        tick;
        chk("bp_occ_hold", s1_occ, 2);
        chk("bp_ctrl_hold", s1_out_ctrl, 8'hA0);
        chk("bp_stall", s1_stall, 2);
        drive(1'b1, 8'hC0, 79'hC, 1'b1);
        chk("bp_rdy_reg", s1_in_ready, 0);
        tick;
        chk("bp_ctrl_b", s1_out_ctrl, 8'hB0);
        chk("bp_rdy_back", s1_in_ready, 1);
        chk("bp_occ_pop", s1_occ, 1);
        tick;
        chk("bp_ctrl_c", s1_out_ctrl, 8'hC0);
        drive(1'b0, 8'h00, 79'h0, 1'b1);
        tick;
        chk("bp_drain", s1_out_valid, 0);
        chk("bp_stall_end", s1_stall, 2);

        // 3: flush with full skid
        drive(1'b1, 8'hD1, 79'hD1D1, 1'b0);
        tick;
        drive(1'b1, 8'hD2, 79'hD2D2, 1'b0);
        tick;
        chk("fl_occ2", s1_occ, 2);
        flush = 1'b1;
        drive(1'b1, 8'hD3, 79'hD3D3, 1'b0);
        chk("fl_rdy", s1_in_ready, 0);
        tick;
        flush = 1'b0;
        drive(1'b0, 8'h00, 79'h0, 1'b0);
        chk("fl_valid", s1_out_valid, 0);
        chk("fl_ctrl", s1_out_ctrl, 0);
        chk("fl_occ", s1_occ, 0);
        chk("fl_data_kept", s1_out_data, 79'hD1D1);
        chk("fl_rdy_after", s1_in_ready, 1);

        // 4: bubble masking keeps data, zeroes ctrl
        drive(1'b1, 8'hFF, 79'h1234_5678, 1'b1);
        tick;
        chk("msk_ctrl_ff", s1_out_ctrl, 8'hFF);
        drive(1'b0, 8'h00, 79'h0, 1'b1);
        tick;
        chk("msk_valid", s1_out_valid, 0);
        chk("msk_ctrl", s1_out_ctrl, 0);
        chk("msk_data", s1_out_data, 79'h1234_5678);

        // 5: SKID=0 combinational ready
        drive(1'b1, 8'h51, 79'h51, 1'b0);
        chk("s0_rdy_empty", s0_in_ready, 1);
        tick;
        chk("s0_occ1", s0_occ, 1);
        drive(1'b1, 8'h52, 79'h52, 1'b1);
        chk("s0_rdy_pop", s0_in_ready, 1);
        tick;
        chk("s0_occ_pp", s0_occ, 1);
        chk("s0_ctrl_52", s0_out_ctrl, 8'h52);
        drive(1'b1, 8'h53, 79'h53, 1'b0);
        chk("s0_rdy_full", s0_in_ready, 0);
        tick;
        chk("s0_ctrl_hold", s0_out_ctrl, 8'h52);
        flush = 1'b1;
        drive(1'b0, 8'h00, 79'h0, 1'b1);
        chk("s0_rdy_flush", s0_in_ready, 0);
        tick;
        flush = 1'b0;
        chk("s0_flushed", s0_occ, 0);

        // 6: saturation, clear, asynchronous reset
        clr_stats = 1'b1;
        drive(1'b1, 8'h61, 79'h61, 1'b0);
        tick;
        clr_stats = 1'b0;
        drive(1'b0, 8'h00, 79'h0, 1'b0);
        chk("sat_clr0", c4_stall, 0);
        repeat (20) tick;
        chk("sat_c4", c4_stall, 15);
        chk("sat_c16", s1_stall, 20);
        chk("sat_bubble", c4_bubble, 0);
        clr_stats = 1'b1;
        tick;
        clr_stats = 1'b0;
        chk("sat_clr_c4", c4_stall, 0);
        chk("sat_clr_c16", s1_stall, 0);
        tick;
        chk("ar_pre_stall", c4_stall, 1);
        chk("ar_pre_valid", c4_out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_valid", c4_out_valid, 0);
        chk("ar_ctrl", c4_out_ctrl, 0);
        chk("ar_data", c4_out_data, 0);
        chk("ar_occ", c4_occ, 0);
        chk("ar_stall", c4_stall, 0);
        chk("ar_bubble", c4_bubble, 0);
        chk("ar_rdy", c4_in_ready, 1);
        #20;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake. It is the successor to the fixed-field ID/EX register. Payload is split into a control field and a data field. The control field is forced to zero whenever the stage holds a bubble, so downstream logic sees a NOP. The stage adds synchronous flush, optional two-entry skid buffering that registers `in_ready`, and saturating stall/bubble statistics counters. One instance is placed between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `CTRL_W`, default 8: control field width; zeroed on bubble/flush/reset.
- `DATA_W`, default 79: data field width (rs1, rs2, rd, immediate, etc.).
- `SKID`, default 1: 1 = two-entry skid with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- `CNT_W`, default 16: statistics counter width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous kill of all held entries.
- `clr_stats`, in, 1: synchronous clear of both counters.
- `in_valid`, in, 1: upstream beat present.
- `in_ready`, out, 1: stage can accept a beat.
- `in_ctrl`, in, CTRL_W: upstream control field.
- `in_data`, in, DATA_W: upstream data field.
- `out_valid`, out, 1: beat present at output.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_ctrl`, out, CTRL_W: output control field; 0 when `out_valid`=0.
- `out_data`, out, DATA_W: output data field; holds its last value when `out_valid`=0.
- `occupancy`, out, 2: number of held entries, 0..2 (0..1 when SKID=0).
- `stall_cnt`, out, CNT_W: cycles with `out_valid`=1 and `out_ready`=0; saturating.
- `bubble_cnt`, out, CNT_W: cycles with `out_valid`=0; saturating.

## Operation
- **Transfers.** Input transfer occurs when `in_valid` & `in_ready`. Output transfer occurs when `out_valid` & `out_ready`.
- **Storage.**
  - Main entry drives the outputs.
  - Skid entry exists only when SKID=1.
  - Each entry holds a valid bit, ctrl and data.
- **SKID=1 update rules (priority order):**
  1. If `flush`: both valid bits go to 0, both ctrl fields go to 0, data is unchanged.
  2. If main is empty or popping: main loads the skid entry if the skid is valid (the skid then loads the input if one is accepted, otherwise it empties). Otherwise main loads the input if one is accepted, otherwise it empties.
  3. Otherwise (main full and not popping): an accepted input goes to the skid.
- **`in_ready` (SKID=1):** `!skid_valid` read from a register. There is no combinational path from `out_ready`.
- **`in_ready` (SKID=0):** `(!main_valid | out_ready) & !flush`.
- **`in_ready` during flush (SKID=1):** forced to 0 in the flush cycle, so no beat is lost.
- **Output side during flush:** unaffected in the flush cycle. A beat presented with `out_ready`=1 counts as transferred.
- **Bubble masking:** `out_ctrl` = main.ctrl & {CTRL_W{main_valid}}.
- **Ordering:** strict FIFO order. No beat is duplicated or dropped except by flush.
- **Counters:**
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1.
  - `clr_stats` sets both to 0, overriding any increment that cycle.
  - Counting is enabled only after the first clock following reset release.

## Timing
- **Reset** (asynchronous, while `reset_n`=0): all valid bits, ctrl, data and counters are 0. Outputs read `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0, `bubble_cnt`=0. `in_ready`=1 (SKID=1) or 1 (SKID=0, since main is empty).
- **Reset mid-operation:** held beats are discarded immediately. No output glitch beyond the asynchronous clear.
- **Latency:** a beat accepted at edge N appears on `out_*` after edge N; 1 cycle.
- **Throughput:** 1 beat/cycle with `out_ready` held high, for both SKID values.
- **Backpressure (SKID=1):**
  - With `out_ready` low and `in_valid` high, 2 beats are absorbed.
  - `in_ready` falls after the second acceptance edge.
  - After `out_ready` rises, `in_ready` returns to 1 one cycle after the first pop.
- **Simultaneous events:**
  - Push and pop in the same cycle leave occupancy unchanged.
  - Flush combined with pop or push gives occupancy 0 next cycle.
  - `clr_stats` combined with a saturated counter gives 0.

## Test plan
1. **Reset then stream, SKID=1.** Release `reset_n`, then drive 5 beats with ctrl=0x11..0x15 and `out_ready`=1 → outputs after a 1-cycle latency, back-to-back with no gaps. `bubble_cnt` counts only the idle cycles.
2. **Backpressure, SKID=1.** Hold `out_ready`=0 while `in_valid`=1 with ctrl A, B, C → A and B are accepted, `in_ready`=0, `occupancy`=2, C is held upstream. Raise `out_ready` → output order is A, B, C. `stall_cnt` equals the number of `out_ready`-low cycles with `out_valid`=1.
3. **Flush with full skid.** `occupancy`=2, assert `flush` for 1 cycle with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0. The input beat is not accepted (`in_ready` was 0).
4. **Bubble masking.** After draining, with main.ctrl last 0xFF → `out_ctrl`=0x00 while `out_data` keeps its last value.
5. **SKID=0 combinational ready.** Main full, `out_ready`=1, `in_valid`=1 → `in_ready`=1 in the same cycle and occupancy stays 1. With `out_ready`=0 → `in_ready`=0.
6. **Counter saturation and async reset, CNT_W=4.** 20 stall cycles → `stall_cnt`=15. Assert `clr_stats` → 0. Then drop `reset_n` mid-stream → all outputs 0 immediately, before the next edge.
